ram_block_mover: RTL and testbench

//  Initiator/master for one port of a dpram instance: executes FILL, COPY and CHECKSUM commands over address ranges.

---
 rtl/ram_mover_pkg.sv | 23 ++
 rtl/ram_mover_csum.sv | 28 ++
 rtl/ram_block_mover.sv | 144 ++++++++++++++
 tb/tb_ram_block_mover.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_mover_pkg.sv
// Shared types for the RAM block mover: command opcodes, FSM states and result width.
package ram_mover_pkg;

  localparam int RESULT_W = 16;

  typedef enum logic [1:0] {
    OP_FILL = 2'd0,
    OP_COPY = 2'd1,
    OP_CSUM = 2'd2,
    OP_RSVD = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_COPY_RD,
    ST_COPY_WR,
    ST_CSUM_RD,
    ST_CSUM_TAIL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram_mover_csum.sv
// Checksum accumulator: a read issued with enable=1 has its data summed one cycle later,
// matching the dpram registered read latency.
module ram_mover_csum
  import ram_mover_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [DATA_W-1:0]   data,
  output logic [RESULT_W-1:0] sum
);

  logic pend;

  always_ff @(posedge clk_sys) begin
    if (reset || clear) begin
      pend <= 1'b0;
      sum  <= '0;
    end else begin
      pend <= enable;
      if (pend) sum <= sum + RESULT_W'(data);
    end
  end

endmodule

// File: rtl/ram_block_mover.sv
// FILL / COPY / CHECKSUM initiator for one dpram port, one command in flight.
// Optional abort support is enabled by defining RAM_MOVER_ABORT_EN.
module ram_block_mover
  import ram_mover_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic [DATA_W-1:0]   cmd_fill,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [RESULT_W-1:0] result,
  output logic                mem_ce,
  output logic                mem_wren,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  input  logic [DATA_W-1:0]   mem_q
);

  localparam int CNT_W = ADDR_W + 1;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   src_addr, dst_addr;
  logic [CNT_W-1:0]    count;
  logic [DATA_W-1:0]   fill_reg;
  logic                accept, last, abort_hit;

  assign accept    = cmd_valid && cmd_ready;
  assign last      = (count == CNT_W'(1));
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign done      = (state == ST_DONE);

`ifdef RAM_MOVER_ABORT_EN
  assign abort_hit = abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= ST_IDLE;
      src_addr <= '0;
      dst_addr <= '0;
      count    <= '0;
      fill_reg <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        src_addr <= cmd_src;
        dst_addr <= cmd_dst;
        count    <= cmd_len;
        fill_reg <= cmd_fill;
      end else begin
        case (state)
          ST_FILL, ST_COPY_WR: begin
            dst_addr <= dst_addr + ADDR_W'(1);
            count    <= count - CNT_W'(1);
          end
          ST_COPY_RD: src_addr <= src_addr + ADDR_W'(1);
          ST_CSUM_RD: begin
            src_addr <= src_addr + ADDR_W'(1);
            count    <= count - CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_ce    = 1'b0;
    mem_wren  = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_len == '0) begin
            state_nxt = ST_DONE;
          end else begin
            case (op_t'(cmd_op))
              OP_FILL: state_nxt = ST_FILL;
              OP_COPY: state_nxt = ST_COPY_RD;
              OP_CSUM: state_nxt = ST_CSUM_RD;
              default: state_nxt = ST_DONE;
            endcase
          end
        end
      end
      ST_FILL: begin
        mem_ce   = 1'b1;
        mem_wren = 1'b1;
        mem_addr = dst_addr;
        mem_data = fill_reg;
        if (last || abort_hit) state_nxt = ST_DONE;
      end
      ST_COPY_RD: begin
        mem_ce    = 1'b1;
        mem_addr  = src_addr;
        state_nxt = abort_hit ? ST_DONE : ST_COPY_WR;
      end
      ST_COPY_WR: begin
        mem_ce    = 1'b1;
        mem_wren  = 1'b1;
        mem_addr  = dst_addr;
        mem_data  = mem_q;
        state_nxt = (last || abort_hit) ? ST_DONE : ST_COPY_RD;
      end
      ST_CSUM_RD: begin
        mem_ce   = 1'b1;
        mem_addr = src_addr;
        // an abort here still lets the in-flight word land in the partial sum
        if (abort_hit)   state_nxt = ST_DONE;
        else if (last)   state_nxt = ST_CSUM_TAIL;
      end
      ST_CSUM_TAIL: state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  ram_mover_csum #(.DATA_W(DATA_W)) u_csum (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (accept),
    .enable  (state == ST_CSUM_RD),
    .data    (mem_q),
    .sum     (result)
  );

endmodule

// File: tb/tb_ram_block_mover.sv
// Self-checking bench for ram_block_mover against a behavioural RAM/command model.
module tb_ram_block_mover;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;
`ifdef RAM_MOVER_ABORT_EN
  localparam int ABORT_WR = 5;
  localparam int ABORT_DONE_CYC = 6;
`else
  localparam int ABORT_WR = 16;
  localparam int ABORT_DONE_CYC = 17;
`endif

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_src = '0, cmd_dst = '0;
  logic [AW:0]   cmd_len = '0;
  logic [DW-1:0] cmd_fill = '0;
  logic          abort = 1'b0;
  logic          busy, done;
  logic [15:0]   result;
  logic          mem_ce, mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q = '0;

  bit [DW-1:0] ram [DEPTH];
  bit [DW-1:0] ref_mem [DEPTH];

  int total = 0;
  int bad = 0;
  int ce_cnt = 0, wr_cnt = 0, done_cnt = 0, idle_ce_bad = 0, busy_done_bad = 0;

  always #5 clk_sys = ~clk_sys;

  ram_block_mover #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_sys(clk_sys), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_fill(cmd_fill), .abort(abort), .busy(busy), .done(done), .result(result),
    .mem_ce(mem_ce), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_q(mem_q)
  );

  always @(posedge clk_sys) begin
    if (mem_ce) begin
      if (mem_wren) ram[mem_addr] <= mem_data;
      else          mem_q <= ram[mem_addr];
    end
  end

  always @(posedge clk_sys) begin
    #1;
    if (mem_ce) ce_cnt++;
    if (mem_ce && mem_wren) wr_cnt++;
    if (done) done_cnt++;
    if (mem_ce && (cmd_ready || done)) idle_ce_bad++;
    if (busy && done) busy_done_bad++;
  end

  // Reference: apply a command to ref_mem word by word, ascending, with address wrap.
  task automatic model_cmd(input int op, input int src, input int dst, input int len,
                           input int fill, output int sum);
    sum = 0;
    for (int i = 0; i < len; i++) begin
      if (op == 0) ref_mem[(dst + i) % DEPTH] = fill[DW-1:0];
      else if (op == 1) ref_mem[(dst + i) % DEPTH] = ref_mem[(src + i) % DEPTH];
      else if (op == 2) sum = (sum + int'(ref_mem[(src + i) % DEPTH])) % 65536;
    end
  endtask

  function automatic int exp_cycles(input int op, input int len);
    if (len == 0 || op == 3) return 1;
    if (op == 0) return len + 1;
    if (op == 1) return 2 * len + 1;
    return len + 2;
  endfunction

  function automatic int mem_diffs();
    int d = 0;
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== ref_mem[a]) d++;
    return d;
  endfunction

  // Offer one command at a negedge and count cycles until done (accept cycle = 0).
  task automatic run_cmd(input int op, input int src, input int dst, input int len,
                         input int fill, output int cyc);
    @(negedge clk_sys);
    ce_cnt = 0; wr_cnt = 0; done_cnt = 0;
    cmd_valid = 1'b1;
    cmd_op = op[1:0]; cmd_src = src[AW-1:0]; cmd_dst = dst[AW-1:0];
    cmd_len = len[AW:0]; cmd_fill = fill[DW-1:0];
    cyc = 0;
    do begin
      @(negedge clk_sys);
      cyc++;
      cmd_valid = 1'b0;
    end while (!done && cyc < 3000);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    total++; if ({busy, done, mem_ce, mem_wren} !== 4'b0000) begin bad++;
      $display("FAIL reset_flags got busy/done/ce/wren=%b exp=0000", {busy, done, mem_ce, mem_wren}); end
    total++; if ({mem_addr, mem_data, result} !== '0) begin bad++;
      $display("FAIL reset_values got addr=%h data=%h result=%h exp=0", mem_addr, mem_data, result); end
  endtask

  task automatic test_fill_wrap();
    int cyc, s;
    run_cmd(0, 0, 'h3FE, 4, 'hA5, cyc);
    model_cmd(0, 0, 'h3FE, 4, 'hA5, s);
    total++; if (cyc !== 5) begin bad++; $display("FAIL fill_latency got=%0d exp=5", cyc); end
    total++; if (wr_cnt !== 4) begin bad++; $display("FAIL fill_writes got=%0d exp=4", wr_cnt); end
    total++; if (mem_diffs() !== 0 || ram[0] !== 8'hA5 || ram[1] !== 8'hA5) begin bad++;
      $display("FAIL fill_wrap_mem diffs=%0d ram0=%h ram1=%h exp=a5", mem_diffs(), ram[0], ram[1]); end
  endtask

  task automatic test_copy();
    int cyc, s;
    int vals[4] = '{11, 22, 33, 44};
    for (int i = 0; i < 4; i++) begin
      run_cmd(0, 0, 'h100 + i, 1, vals[i], cyc);
      model_cmd(0, 0, 'h100 + i, 1, vals[i], s);
    end
    run_cmd(1, 'h100, 'h200, 4, 0, cyc);
    model_cmd(1, 'h100, 'h200, 4, 0, s);
    total++; if (cyc !== 9) begin bad++; $display("FAIL copy_latency got=%0d exp=9", cyc); end
    total++; if (ce_cnt !== 8) begin bad++; $display("FAIL copy_access got=%0d exp=8", ce_cnt); end
    total++; if (mem_diffs() !== 0 || ram['h203] !== 8'd44) begin bad++;
      $display("FAIL copy_mem diffs=%0d ram203=%0d exp=44", mem_diffs(), ram['h203]); end
  endtask

  task automatic test_csum();
    int cyc, s;
    run_cmd(0, 0, 'h010, 3, 'hFF, cyc);
    model_cmd(0, 0, 'h010, 3, 'hFF, s);
    run_cmd(2, 'h010, 0, 3, 0, cyc);
    total++; if (result !== 16'h02FD) begin bad++; $display("FAIL csum3 got=%h exp=02fd", result); end
    total++; if (cyc !== 5) begin bad++; $display("FAIL csum3_latency got=%0d exp=5", cyc); end
    run_cmd(0, 0, 0, 1024, 'hFF, cyc);
    model_cmd(0, 0, 0, 1024, 'hFF, s);
    total++; if (wr_cnt !== 1024) begin bad++; $display("FAIL fill_full_writes got=%0d exp=1024", wr_cnt); end
    run_cmd(2, 'h155, 0, 1024, 0, cyc);
    total++; if (result !== 16'hFC00) begin bad++; $display("FAIL csum_full got=%h exp=fc00", result); end
    total++; if (cyc !== 1026) begin bad++; $display("FAIL csum_full_latency got=%0d exp=1026", cyc); end
  endtask

  task automatic test_len_zero();
    int cyc;
    for (int op = 0; op < 4; op++) begin
      run_cmd(op, 'h20, 'h30, 0, 'h77, cyc);
      total++; if (cyc !== 1 || ce_cnt !== 0) begin bad++;
        $display("FAIL len0_op%0d got cyc=%0d ce=%0d exp cyc=1 ce=0", op, cyc, ce_cnt); end
    end
    run_cmd(3, 'h20, 'h30, 5, 'h77, cyc);
    total++; if (cyc !== 1 || ce_cnt !== 0 || result !== 16'h0) begin bad++;
      $display("FAIL rsvd_op got cyc=%0d ce=%0d result=%h exp 1/0/0", cyc, ce_cnt, result); end
  endtask

  task automatic test_random();
    int cyc, s, op, src, dst, len, fill;
    for (int n = 0; n < 30; n++) begin
      op   = (n < 6) ? 0 : int'($urandom_range(0, 3));
      src  = int'($urandom_range(0, DEPTH - 1));
      dst  = int'($urandom_range(0, DEPTH - 1));
      len  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, (n < 6) ? 300 : 40));
      fill = int'($urandom_range(0, 255));
      run_cmd(op, src, dst, len, fill, cyc);
      model_cmd(op, src, dst, len, fill, s);
      total++; if (cyc !== exp_cycles(op, len)) begin bad++;
        $display("FAIL rnd%0d_latency op=%0d len=%0d got=%0d exp=%0d", n, op, len, cyc, exp_cycles(op, len)); end
      total++; if (result !== 16'(s)) begin bad++;
        $display("FAIL rnd%0d_result op=%0d got=%h exp=%h", n, op, result, s[15:0]); end
      total++; if (mem_diffs() !== 0) begin bad++;
        $display("FAIL rnd%0d_mem op=%0d diffs=%0d exp=0", n, op, mem_diffs()); end
    end
  endtask

  task automatic test_back_to_back();
    int c, s;
    @(negedge clk_sys);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dst = 'h50; cmd_len = 3; cmd_fill = 8'h11;
    @(negedge clk_sys);
    cmd_dst = 'h60; cmd_len = 2; cmd_fill = 8'h22;
    c = 1;
    while (!done && c < 50) begin @(negedge clk_sys); c++; end
    total++; if (c !== 4 || cmd_ready !== 1'b0) begin bad++;
      $display("FAIL b2b_first got cyc=%0d ready=%b exp cyc=4 ready=0", c, cmd_ready); end
    @(negedge clk_sys);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_return got=%b exp=1", cmd_ready); end
    @(negedge clk_sys);
    cmd_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept got busy=%b exp=1", busy); end
    c = 0;
    while (!done && c < 50) begin @(negedge clk_sys); c++; end
    model_cmd(0, 0, 'h50, 3, 'h11, s);
    model_cmd(0, 0, 'h60, 2, 'h22, s);
    total++; if (mem_diffs() !== 0) begin bad++; $display("FAIL b2b_mem diffs=%0d exp=0", mem_diffs()); end
  endtask

  task automatic test_abort();
    int c, s;
    @(negedge clk_sys);
    wr_cnt = 0; done_cnt = 0;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dst = 'h80; cmd_len = 16; cmd_fill = 8'h5A;
    for (c = 1; c <= 5; c++) begin @(negedge clk_sys); cmd_valid = 1'b0; end
    c = 5;
    abort = 1'b1;
    while (!done && c < 60) begin @(negedge clk_sys); abort = 1'b0; c++; end
    abort = 1'b0;
    model_cmd(0, 0, 'h80, ABORT_WR, 'h5A, s);
    total++; if (wr_cnt !== ABORT_WR) begin bad++; $display("FAIL abort_writes got=%0d exp=%0d", wr_cnt, ABORT_WR); end
    total++; if (c !== ABORT_DONE_CYC) begin bad++; $display("FAIL abort_done_cycle got=%0d exp=%0d", c, ABORT_DONE_CYC); end
    total++; if (mem_diffs() !== 0) begin bad++; $display("FAIL abort_mem diffs=%0d exp=0", mem_diffs()); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_sys);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_src = 'h100; cmd_dst = 'h300; cmd_len = 8;
    @(negedge clk_sys);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    total++; if (mem_wren !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL rst_mid_stop got wren=%b busy=%b exp 0/0", mem_wren, busy); end
    reset = 1'b0;
    wr_cnt = 0; done_cnt = 0;
    repeat (10) @(negedge clk_sys);
    total++; if (wr_cnt !== 0 || done_cnt !== 0) begin bad++;
      $display("FAIL rst_mid_quiet got wr=%0d done=%0d exp 0/0", wr_cnt, done_cnt); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_invariants();
    total++; if (idle_ce_bad !== 0) begin bad++; $display("FAIL ce_in_idle_done got=%0d exp=0", idle_ce_bad); end
    total++; if (busy_done_bad !== 0) begin bad++; $display("FAIL busy_with_done got=%0d exp=0", busy_done_bad); end
  endtask

  initial begin
    test_reset();
    test_fill_wrap();
    test_copy();
    test_csum();
    test_len_zero();
    test_random();
    test_back_to_back();
    test_abort();
    test_invariants();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
